// File: rtl/project_top.sv
// Board shell for the image decompressor: loads the compressed stream into SRAM
// over UART, starts the decoder after a line-idle timeout, and shows SRAM via VGA.

module uart_sram_if #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        rx_i,
  output logic [17:0] addr_o,
  output logic [15:0] wdata_o,
  output logic        we_n_o,
  output logic        strobe_o
);
  logic        busy_q, strobe_q, got_hi_q, we_n_q;
  logic [15:0] cnt_q;
  logic [3:0]  bitn_q;
  logic [7:0]  shift_q, hi_q;
  logic [17:0] addr_q;
  logic [15:0] wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0; strobe_q <= 1'b0; cnt_q <= '0; bitn_q <= '0; shift_q <= '0;
      got_hi_q <= 1'b0; hi_q <= '0; addr_q <= '0; wdata_q <= '0; we_n_q <= 1'b1;
    end else begin
      strobe_q <= 1'b0;
      // Start bit found: first data bit is sampled 1.5 bit times later, at its centre.
      if (!busy_q) begin
        if (!rx_i) begin
          busy_q <= 1'b1;
          cnt_q  <= 16'(CLKS_PER_BIT + CLKS_PER_BIT / 2 - 1);
          bitn_q <= '0;
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 16'd1;
      end else if (bitn_q != 4'd8) begin
        shift_q <= {rx_i, shift_q[7:1]};
        bitn_q  <= bitn_q + 4'd1;
        cnt_q   <= 16'(CLKS_PER_BIT - 1);
      end else begin
        busy_q   <= 1'b0;
        strobe_q <= 1'b1;
      end

      we_n_q <= 1'b1;
      if (enable_i) begin
        addr_q   <= 18'd76800;
        got_hi_q <= 1'b0;
      end else begin
        if (!we_n_q) addr_q <= addr_q + 18'd1;
        if (strobe_q) begin
          if (!got_hi_q) begin
            hi_q     <= shift_q;
            got_hi_q <= 1'b1;
          end else begin
            wdata_q  <= {hi_q, shift_q};
            we_n_q   <= 1'b0;
            got_hi_q <= 1'b0;
          end
        end
      end
    end
  end

  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign we_n_o   = we_n_q;
  assign strobe_o = strobe_q;
endmodule

module vga_sram_if (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] base_i,
  input  logic [15:0] rdata_i,
  output logic [17:0] addr_o,
  output logic        vga_clk_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        blank_o,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o
);
  logic        pix_q, hs_q, vs_q, blank_q, visible;
  logic [9:0]  h_q, v_q;
  logic [17:0] addr_q;
  logic [23:0] rgb_q;

  assign visible = (h_q < 10'd640) && (v_q < 10'd480);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= 1'b0; h_q <= '0; v_q <= '0; addr_q <= '0;
      hs_q <= 1'b1; vs_q <= 1'b1; blank_q <= 1'b0; rgb_q <= '0;
    end else begin
      pix_q <= ~pix_q;
      if (pix_q) begin
        if (h_q == 10'd799) begin
          h_q <= '0;
          v_q <= (v_q == 10'd524) ? '0 : v_q + 10'd1;
        end else begin
          h_q <= h_q + 10'd1;
        end
        if (h_q == '0 && v_q == '0) addr_q <= base_i;
        else if (visible && h_q[0]) addr_q <= addr_q + 18'd1;
        hs_q    <= !(h_q >= 10'd656 && h_q < 10'd752);
        vs_q    <= !(v_q >= 10'd490 && v_q < 10'd492);
        blank_q <= visible;
        rgb_q   <= visible ? {rdata_i[15:8], rdata_i[7:0], rdata_i[15:8]} : '0;
      end
    end
  end

  assign addr_o    = addr_q;
  assign vga_clk_o = pix_q;
  assign hsync_o   = hs_q;
  assign vsync_o   = vs_q;
  assign blank_o   = blank_q;
  assign {red_o, green_o, blue_o} = rgb_q;
endmodule

module decoder_core #(
  parameter int unsigned WORDS    = 76800,
  parameter logic [17:0] SRC_BASE = 18'd76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] rdata_i,
  output logic [17:0] addr_o,
  output logic [15:0] wdata_o,
  output logic        we_n_o,
  output logic        done_o
);
  logic        busy_q, we_n_q, done_q;
  logic [1:0]  ph_q;
  logic [17:0] idx_q, addr_q;
  logic [15:0] wdata_q;

  // One word per four cycles: issue read, wait out the 2-cycle latency, write back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0; we_n_q <= 1'b1; done_q <= 1'b0; ph_q <= '0;
      idx_q <= '0; addr_q <= '0; wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        busy_q <= 1'b1; ph_q <= 2'd1; idx_q <= '0; addr_q <= SRC_BASE;
      end else if (busy_q) begin
        unique case (ph_q)
          2'd0: begin
            we_n_q <= 1'b1;
            if (idx_q == 18'(WORDS - 1)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx_q  <= idx_q + 18'd1;
              addr_q <= SRC_BASE + idx_q + 18'd1;
              ph_q   <= 2'd1;
            end
          end
          2'd1: ph_q <= 2'd2;
          2'd2: ph_q <= 2'd3;
          default: begin
            wdata_q <= rdata_i; addr_q <= idx_q; we_n_q <= 1'b0; ph_q <= 2'd0;
          end
        endcase
      end
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign we_n_o  = we_n_q;
  assign done_o  = done_q;
endmodule

module project_top #(
  parameter logic [25:0] UART_TIMEOUT      = 26'd49_999_999,
  parameter logic [17:0] VGA_BASE          = 18'd146_944,
  parameter int unsigned UART_CLKS_PER_BIT = 434,
  parameter int unsigned DECODE_WORDS      = 76800
) (
  input  logic            CLOCK_50_I,
  input  logic [17:0]     SWITCH_I,
  input  logic [3:0]      PUSH_BUTTON_N_I,
  input  logic            UART_RX_I,
  output logic            UART_TX_O,
  output logic [7:0][6:0] SEVEN_SEGMENT_N_O,
  output logic [8:0]      LED_GREEN_O,
  output logic            VGA_CLOCK_O,
  output logic            VGA_HSYNC_O,
  output logic            VGA_VSYNC_O,
  output logic            VGA_BLANK_O,
  output logic            VGA_SYNC_O,
  output logic [7:0]      VGA_RED_O,
  output logic [7:0]      VGA_GREEN_O,
  output logic [7:0]      VGA_BLUE_O,
  inout  wire  [15:0]     SRAM_DATA_IO,
  output logic [19:0]     SRAM_ADDRESS_O,
  output logic            SRAM_UB_N_O,
  output logic            SRAM_LB_N_O,
  output logic            SRAM_WE_N_O,
  output logic            SRAM_CE_N_O,
  output logic            SRAM_OE_N_O
);
  typedef enum logic [1:0] {S_IDLE, S_ENABLE_UART_RX, S_WAIT_UART_RX, S_DECODE} top_state_t;

  logic        clk, rst, unused_inputs;
  top_state_t  top_state;
  logic [25:0] UART_timer;
  logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_fall, decoder_start_q;
  logic        SRAM_we_n, uart_we_n, dec_we_n, uart_rx_strobe, dec_done;
  logic [17:0] SRAM_address, VGA_base_address, vga_addr, uart_addr, dec_addr;
  logic [15:0] SRAM_write_data, SRAM_read_data, uart_wdata, dec_wdata;

  assign clk              = CLOCK_50_I;
  assign rst              = SWITCH_I[17];
  assign unused_inputs    = &{1'b0, SWITCH_I[16:0], PUSH_BUTTON_N_I};
  assign VGA_base_address = VGA_BASE;
  assign rx_fall          = !rx_sync_q && rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_state <= S_IDLE; UART_timer <= '0; decoder_start_q <= 1'b0;
      rx_meta_q <= 1'b1; rx_sync_q <= 1'b1; rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX_I;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      decoder_start_q <= 1'b0;
      unique case (top_state)
        S_IDLE: if (rx_fall) top_state <= S_ENABLE_UART_RX;
        S_ENABLE_UART_RX: begin
          UART_timer <= '0;
          top_state  <= S_WAIT_UART_RX;
        end
        S_WAIT_UART_RX: begin
          if (UART_timer == UART_TIMEOUT) begin
            UART_timer      <= '0;
            decoder_start_q <= 1'b1;
            top_state       <= S_DECODE;
          end else if (uart_rx_strobe) begin
            UART_timer <= '0;
          end else begin
            UART_timer <= UART_timer + 26'd1;
          end
        end
        default: if (dec_done && !decoder_start_q) top_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    unique case (top_state)
      S_IDLE:         SRAM_address = vga_addr;
      S_WAIT_UART_RX: {SRAM_address, SRAM_write_data, SRAM_we_n} = {uart_addr, uart_wdata, uart_we_n};
      S_DECODE:       {SRAM_address, SRAM_write_data, SRAM_we_n} = {dec_addr, dec_wdata, dec_we_n};
      default: ;
    endcase
  end

  always_comb begin
    SEVEN_SEGMENT_N_O = '1;
    unique case (top_state)
      S_IDLE:           SEVEN_SEGMENT_N_O[0] = 7'h40;
      S_ENABLE_UART_RX: SEVEN_SEGMENT_N_O[0] = 7'h79;
      S_WAIT_UART_RX:   SEVEN_SEGMENT_N_O[0] = 7'h24;
      default:          SEVEN_SEGMENT_N_O[0] = 7'h30;
    endcase
  end

  assign LED_GREEN_O    = {5'b0, 4'b0001 << top_state};
  assign UART_TX_O      = 1'b1;
  assign VGA_SYNC_O     = 1'b0;
  assign SRAM_read_data = SRAM_DATA_IO;
  assign SRAM_DATA_IO   = SRAM_we_n ? 'z : SRAM_write_data;
  assign SRAM_ADDRESS_O = {2'b00, SRAM_address};
  assign SRAM_WE_N_O    = SRAM_we_n;
  assign {SRAM_UB_N_O, SRAM_LB_N_O, SRAM_CE_N_O, SRAM_OE_N_O} = '0;

  uart_sram_if #(.CLKS_PER_BIT(UART_CLKS_PER_BIT)) UART_unit (
    .clk(clk), .rst(rst), .enable_i(top_state == S_ENABLE_UART_RX), .rx_i(rx_sync_q),
    .addr_o(uart_addr), .wdata_o(uart_wdata), .we_n_o(uart_we_n), .strobe_o(uart_rx_strobe)
  );

  vga_sram_if VGA_unit (
    .clk(clk), .rst(rst), .base_i(VGA_base_address), .rdata_i(SRAM_read_data), .addr_o(vga_addr),
    .vga_clk_o(VGA_CLOCK_O), .hsync_o(VGA_HSYNC_O), .vsync_o(VGA_VSYNC_O), .blank_o(VGA_BLANK_O),
    .red_o(VGA_RED_O), .green_o(VGA_GREEN_O), .blue_o(VGA_BLUE_O)
  );

  decoder_core #(.WORDS(DECODE_WORDS), .SRC_BASE(18'd76800)) IDCT_unit (
    .clk(clk), .rst(rst), .start_i(decoder_start_q), .rdata_i(SRAM_read_data),
    .addr_o(dec_addr), .wdata_o(dec_wdata), .we_n_o(dec_we_n), .done_o(dec_done)
  );
endmodule

// File: tb/tb_project_top.sv
// Directed bench for project_top: reset, UART edge latency, strobe/timeout timing,
// a short load-and-decode pass and reset during decode, against a 2-cycle SRAM model.

module tb_project_top;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx  = 1'b1;
  logic [17:0]     sw;
  logic [3:0]      pb = 4'hF;
  logic            tx, vga_clk, hs, vs, blank, vsync_o;
  logic [7:0][6:0] seg;
  logic [8:0]      led;
  logic [7:0]      r, g, b;
  logic [19:0]     sram_addr;
  logic            ub_n, lb_n, we_n, ce_n, oe_n;
  wire  [15:0]     sram_dq;

  logic [15:0] mem [0:262143];
  logic [17:0] rd_a1 = '0, rd_a2 = '0;

  int n_cmp = 0, n_bad = 0;
  int wr_total = 0, wr_bad = 0, start_pulses = 0;
  int wr_cnt [0:3];

  assign sw = {rst, 17'd0};
  always #5 clk = ~clk;

  project_top #(
    .UART_TIMEOUT(26'd300),
    .UART_CLKS_PER_BIT(8),
    .DECODE_WORDS(4)
  ) dut (
    .CLOCK_50_I(clk), .SWITCH_I(sw), .PUSH_BUTTON_N_I(pb), .UART_RX_I(rx), .UART_TX_O(tx),
    .SEVEN_SEGMENT_N_O(seg), .LED_GREEN_O(led),
    .VGA_CLOCK_O(vga_clk), .VGA_HSYNC_O(hs), .VGA_VSYNC_O(vs), .VGA_BLANK_O(blank),
    .VGA_SYNC_O(vsync_o), .VGA_RED_O(r), .VGA_GREEN_O(g), .VGA_BLUE_O(b),
    .SRAM_DATA_IO(sram_dq), .SRAM_ADDRESS_O(sram_addr), .SRAM_UB_N_O(ub_n), .SRAM_LB_N_O(lb_n),
    .SRAM_WE_N_O(we_n), .SRAM_CE_N_O(ce_n), .SRAM_OE_N_O(oe_n)
  );

  assign sram_dq = we_n ? mem[rd_a2] : 'z;

  always @(posedge clk) begin
    rd_a1 <= sram_addr[17:0];
    rd_a2 <= rd_a1;
    if (!we_n) begin
      mem[sram_addr[17:0]] <= sram_dq;
      wr_total <= wr_total + 1;
      if (dut.top_state == 2'd3) begin
        if (sram_addr < 20'd4) wr_cnt[sram_addr[1:0]] <= wr_cnt[sram_addr[1:0]] + 1;
        else wr_bad <= wr_bad + 1;
      end
    end
    if (dut.decoder_start_q) start_pulses <= start_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic uart_byte(input logic [7:0] d);
    rx = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (8) tick();
    end
    rx = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    int k, found;
    logic [7:0][6:0] seg_exp;
    for (int i = 0; i < 262144; i++) mem[i] = '0;
    mem[76802] = 16'hBEEF;
    mem[76803] = 16'h1234;
    for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
    seg_exp    = '1;
    seg_exp[0] = 7'h40;

    // Reset state
    repeat (3) tick();
    chk("rst_state", 32'(dut.top_state), 0);
    chk("rst_we_n", 32'(we_n), 1);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_timer", 32'(dut.UART_timer), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_seg", 32'(seg), 32'(seg_exp));
    chk("rst_seg_hi", 32'(seg[7:4]), 32'hFFFFFFF);
    chk("rst_led", 32'(led), 32'h001);
    rst = 1'b0;
    repeat (4) tick();

    // Falling edge: 5-cycle low pulse, received as 0xFF
    rx = 1'b0;
    k  = 0;
    for (int i = 1; i <= 6 && k == 0; i++) begin
      tick();
      if (dut.top_state == 2'd1) k = i;
    end
    chk("edge_latency", 32'(k), 3);
    tick();
    chk("enter_wait", 32'(dut.top_state), 2);
    chk("wait_seg0", 32'(seg[0]), 32'h24);
    chk("wait_led", 32'(led), 32'h004);
    tick();
    rx = 1'b1;

    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      if (dut.uart_rx_strobe) found = 1;
    end
    chk("strobe_seen", 32'(found), 1);
    tick();
    chk("strobe_timer_clear", 32'(dut.UART_timer), 0);
    chk("strobe_state", 32'(dut.top_state), 2);

    uart_byte(8'hA1);
    uart_byte(8'hB2);
    uart_byte(8'hC3);

    // Timeout from UART_timer = 290 with limit 300: 11 edges
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      if (dut.UART_timer == 26'd290) found = 1;
    end
    chk("timer_reached", 32'(found), 1);
    k = 0;
    for (int i = 1; i <= 30 && k == 0; i++) begin
      tick();
      if (dut.top_state == 2'd3) k = i;
    end
    chk("timeout_edges", 32'(k), 11);
    chk("decode_timer_clear", 32'(dut.UART_timer), 0);

    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      if (dut.top_state == 2'd0) found = 1;
    end
    chk("done_to_idle", 32'(found), 1);
    chk("load_word0", 32'(mem[76800]), 32'hFFA1);
    chk("load_word1", 32'(mem[76801]), 32'hB2C3);
    chk("dec_word0", 32'(mem[0]), 32'hFFA1);
    chk("dec_word1", 32'(mem[1]), 32'hB2C3);
    chk("dec_word2", 32'(mem[2]), 32'hBEEF);
    chk("dec_word3", 32'(mem[3]), 32'h1234);
    for (int i = 0; i < 4; i++) chk("dec_write_once", 32'(wr_cnt[i]), 1);
    chk("dec_write_range", 32'(wr_bad), 0);
    chk("start_pulses", 32'(start_pulses), 1);
    chk("idle_led", 32'(led), 32'h001);
    chk("idle_we_n", 32'(we_n), 1);

    // Reset in the middle of a decode
    uart_byte(8'h5A);
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      if (dut.top_state == 2'd3) found = 1;
    end
    chk("second_decode", 32'(found), 1);
    tick();
    tick();
    k = wr_total;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(dut.top_state), 0);
    chk("async_rst_we_n", 32'(we_n), 1);
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("no_writes_after_rst", 32'(wr_total), 32'(k));
    chk("post_rst_state", 32'(dut.top_state), 0);
    chk("post_rst_seg0", 32'(seg[0]), 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
